uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8-bit receiver used on the 50 MHz board designs. It adds:
- configurable data width
- an input synchroniser
- start-bit glitch rejection
- stop-bit checking with framing error
- break recovery
- a valid/ready output holding register with overrun detection
- optional parity

It sits between the board RX pin and any byte consumer (command parser, FIFO).

---
 rtl/uart_rx_param.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, start-glitch rejection, stop/break handling
// and a valid/ready holding register with overrun pulse. Parity bit enabled by `UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_ODD  = 0,
    parameter int BIT_PERIOD  = CLK_FREQ / BAUD_RATE,
    parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [3:0]  IDX_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    state_t                 state, state_next;
    logic                   rx_meta, rx_s;
    logic [15:0]            cnt;
    logic [3:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   sample;
    logic                   complete;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (cnt == HALF_LAST) begin
                sample     = 1'b1;
                state_next = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_LAST) begin
                sample = 1'b1;
                if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == BIT_LAST) begin
                sample     = 1'b1;
                state_next = STOP;
            end
`endif
            // Leaving at mid-stop lets the next start edge be seen with only one stop bit.
            STOP: if (cnt == BIT_LAST) begin
                sample     = 1'b1;
                state_next = rx_s ? IDLE : BREAK;
            end
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign complete = (state == STOP) && sample;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_next != state || sample || state == IDLE || state == BREAK) cnt <= '0;
            else cnt <= cnt + 16'd1;
            if (state == START) bit_idx <= '0;
            else if (state == DATA && sample) bit_idx <= bit_idx + 4'd1;
            if (state == DATA && sample) begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (bit_idx == 4'(i)) shreg[i] <= rx_s;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic par_bit;
    logic par_calc;

    always_ff @(posedge clk) begin
        if (reset)                            par_bit <= 1'b0;
        else if (state == PARITY && sample)   par_bit <= rx_s;
    end

    assign par_calc = ((^shreg) ^ par_bit) != PAR_SENSE;
`else
    logic unused_par_sense;
    assign unused_par_sense = (PARITY_ODD != 0);
    assign parity_err       = 1'b0;
`endif

    // Holding register handshake: a word is transferred on any edge where valid && ready.
    // A completion may refill it on that same edge; completing while full and not draining
    // drops the new word and pulses overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!valid || ready) begin
                    data_out   <= shreg;
                    valid      <= 1'b1;
                    frame_err  <= !rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err <= par_calc;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx_param;
    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int DW        = 8;
    localparam int BIT       = CLK_FREQ / BAUD_RATE;
    localparam int W         = DW + 2;
    localparam logic PAR_ODD = 1'b0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          ready = 1'b1;
    logic [DW-1:0] data_out;
    logic          valid, frame_err, parity_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int perr_seen = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(DW), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .ready(ready), .data_out(data_out),
        .valid(valid), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    // Monitor: records every word the consumer takes and every overrun pulse.
    always @(posedge clk) begin
        if (!reset) begin
            if (valid && ready) got_q.push_back({parity_err, frame_err, data_out});
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (valid && parity_err) perr_seen <= perr_seen + 1;
        end
    end

    // Reference: each frame yields {parity_err, frame_err, data}.
    function automatic logic [W-1:0] model_word(input logic [DW-1:0] d, input logic stop,
                                                input logic par);
        logic perr;
`ifdef UART_RX_PARITY_EN
        perr = (((^d) ^ par) != PAR_ODD);
`else
        perr = 1'b0 & par;
`endif
        return {perr, ~stop, d};
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    // Called aligned to a negedge; leaves rx at the stop-bit level.
    task automatic drive_frame(input logic [DW-1:0] d, input logic stop, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({data_out, valid, frame_err, parity_err, overrun, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b fe=%b pe=%b ov=%b busy=%b expected all 0",
                     data_out, valid, frame_err, parity_err, overrun, busy);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [W-1:0] w;
        lat = 0;
        fork
            drive_frame(8'hA5, 1'b1, 1'b0);
            begin
                while (!valid && lat < 300) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (lat < 96 || lat > 98) begin
            errors++;
            $display("FAIL basic_latency got %0d cycles expected 96..98", lat);
        end
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL basic_count got %0d words expected 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            checks++;
            if (w !== model_word(8'hA5, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL basic_word got %h expected %h", w, model_word(8'hA5, 1'b1, 1'b0));
            end
        end
        got_q.delete();
        checks++;
        if (ovr_cnt != 0) begin
            errors++;
            $display("FAIL basic_overrun got %0d pulses expected 0", ovr_cnt);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_before_mid got busy=%b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_at_mid got busy=%b expected 0", busy);
        end
        repeat (120) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_word got %0d words valid=%b expected 0 words valid=0",
                     got_q.size(), valid);
        end
        got_q.delete();
    endtask

    task automatic test_break();
        logic [W-1:0] w;
        drive_frame(8'h3C, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy_low got busy=%b expected 1", busy);
        end
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL break_count got %0d words expected 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            checks++;
            if (w !== model_word(8'h3C, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL break_word got %h expected %h", w, model_word(8'h3C, 1'b0, 1'b0));
            end
        end
        got_q.delete();
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL break_release got busy=%b expected 0", busy);
        end
        drive_frame(8'h01, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== model_word(8'h01, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL break_next_word got %0d words first=%h expected 1 word %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, model_word(8'h01, 1'b1, 1'b1));
        end
        got_q.delete();
    endtask

    task automatic test_overrun();
        int ovr0;
        ovr0  = ovr_cnt;
        ready = 1'b0;
        drive_frame(8'h11, 1'b1, 1'b0);
        drive_frame(8'h22, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data_out !== 8'h11 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL overrun_hold got v=%b data=%h fe=%b expected v=1 data=11 fe=0",
                     valid, data_out, frame_err);
        end
        checks++;
        if (ovr_cnt - ovr0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses got %0d expected 1", ovr_cnt - ovr0);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL overrun_drain got v=%b data=%h expected v=0 data=11", valid, data_out);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== model_word(8'h11, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL overrun_taken got %0d words expected only %h",
                     got_q.size(), model_word(8'h11, 1'b1, 1'b0));
        end
        got_q.delete();
        ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        fork
            drive_frame(8'hFF, 1'b1, 1'b1);
            begin
                repeat (BIT * 5 + 3) @(negedge clk);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_mid_busy got busy=%b expected 1", busy);
                end
                reset = 1'b1;
                @(negedge clk);
                checks++;
                if ({data_out, valid, frame_err, parity_err, overrun, busy} !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_outputs got data=%h v=%b fe=%b pe=%b ov=%b busy=%b expected all 0",
                             data_out, valid, frame_err, parity_err, overrun, busy);
                end
                reset = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_word got %0d words expected 0", got_q.size());
        end
        got_q.delete();
        drive_frame(8'h80, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== model_word(8'h80, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL reset_mid_next got %0d words expected %h",
                     got_q.size(), model_word(8'h80, 1'b1, 1'b1));
        end
        got_q.delete();
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic          stop, par;
        logic [W-1:0]  w, e;
        int            ovr0, n;
        ovr0 = ovr_cnt;
        exp_q.delete();
        for (int f = 0; f < 24; f++) begin
            d    = DW'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            par  = 1'($urandom_range(0, 1));
            exp_q.push_back(model_word(d, stop, par));
            drive_frame(d, stop, par);
            if (!stop) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rx = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            w = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (w !== e) begin
                errors++;
                $display("FAIL random_word[%0d] got %h expected %h", i, w, e);
            end
        end
        checks++;
        if (ovr_cnt != ovr0) begin
            errors++;
            $display("FAIL random_overrun got %0d pulses expected 0", ovr_cnt - ovr0);
        end
        got_q.delete();
    endtask

    task automatic test_parity_flag();
        checks++;
`ifdef UART_RX_PARITY_EN
        if (perr_seen == 0) begin
            errors++;
            $display("FAIL parity_seen got 0 flagged words expected some");
        end
`else
        if (perr_seen != 0) begin
            errors++;
            $display("FAIL parity_tied got %0d flagged words expected 0", perr_seen);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        test_random();
        test_parity_flag();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
